agc_timepulse_gen: RTL

Master timepulse generator for the AGC logic model. It divides the simulation clock into memory cycles (MCTs) of NT one-hot timepulses T01..T12. Each timepulse lasts PHASES clocks. The outputs drive the inputs of the NOR-gate chip models downstream. Supports monitor stop (halt at end of MCT) and single-step of one full MCT.

---
 rtl/agc_timepulse_gen.sv | 139 +++++++++++++
 1 files changed

// File: rtl/agc_timepulse_gen.sv
// rtl/agc_timepulse_gen.sv - AGC master timepulse generator (T01..T12 memory-cycle sequencer)
//
// Divides clk into memory cycles (MCTs) of NT one-hot timepulses, each PHASES
// clocks long. A monitor stop halts the generator at the end of an MCT; with
// TP_STEP_EN defined a rising edge on step runs exactly one more MCT.
//
// Optional feature macro: TP_STEP_EN (single-step logic; undefined = HALT exits
// only when stop drops, step port ignored).
//
// Ports:
//   clk        in   simulation clock, rising edge
//   rst        in   synchronous active-high reset
//   stop       in   monitor stop request (level)
//   step       in   single-step request (rising edge)
//   t          out  [NT-1:0] one-hot timepulse, bit 0 = T01
//   phase      out  [3:0] clock index within the timepulse
//   tp_edge    out  first clock of each timepulse while running
//   mct_end    out  last clock of the last timepulse while running
//   mct_count  out  [CNT_W-1:0] completed memory cycles, wrapping
//   halted     out  generator frozen at end of MCT

module agc_timepulse_gen #(
    parameter int PHASES = 4,
    parameter int NT     = 12,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic             step,
    output logic [NT-1:0]    t,
    output logic [3:0]       phase,
    output logic             tp_edge,
    output logic             mct_end,
    output logic [CNT_W-1:0] mct_count,
    output logic             halted
);

`ifdef TP_STEP_EN
    typedef enum logic [1:0] {S_RUN = 2'd0, S_HALT = 2'd1, S_STEP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {S_RUN = 1'b0, S_HALT = 1'b1} state_t;
`endif

    localparam logic [3:0] PH_LAST = 4'(PHASES - 1);

    state_t state;
    state_t state_nxt;
    logic   last_phase;
    logic   boundary;

    assign last_phase = (phase == PH_LAST);
    // The MCT boundary only exists while the generator is actually running.
    assign boundary   = (state != S_HALT) && t[NT-1] && last_phase;

`ifdef TP_STEP_EN
    logic step_q;
    logic step_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    assign step_rise = step && !step_q;
`else
    logic unused_step;
    assign unused_step = step;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop is only looked at on a boundary or while halted,
    // so a mid-MCT stop always lets the cycle finish.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (boundary && stop) state_nxt = S_HALT;
            end
`ifdef TP_STEP_EN
            S_STEP: begin
                if (boundary) state_nxt = stop ? S_HALT : S_RUN;
            end
`endif
            S_HALT: begin
                if (!stop) state_nxt = S_RUN;
`ifdef TP_STEP_EN
                else if (step_rise) state_nxt = S_STEP;
`endif
            end
            default: state_nxt = S_RUN;
        endcase
    end

    // Timepulse / phase / cycle counter datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            t         <= NT'(1);
            phase     <= 4'd0;
            mct_count <= '0;
        end else if (state == S_HALT) begin
            // Leaving HALT restarts cleanly at T01 phase 0.
            if (state_nxt != S_HALT) begin
                t     <= NT'(1);
                phase <= 4'd0;
            end
        end else begin
            if (boundary) mct_count <= mct_count + CNT_W'(1);
            if (last_phase) begin
                // Entering HALT freezes T12 at its last phase.
                if (state_nxt != S_HALT) begin
                    phase <= 4'd0;
                    t     <= {t[NT-2:0], t[NT-1]};
                end
            end else begin
                phase <= phase + 4'd1;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        halted  = (state == S_HALT);
        tp_edge = (state != S_HALT) && (phase == 4'd0);
        mct_end = boundary;
    end

endmodule
